// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA transfer sequencer.
//   stat_code_t  : completion status reported to the register file
//   xfer_state_t : sequencer FSM states (also exported on the debug port)
//   BEAT_BYTES   : data-beat width in bytes; addresses and lengths must be
//                  multiples of it
package dma_pkg;

    localparam int ADDR_W     = 32;
    localparam int BYTES_W    = 13;  // holds a byte count of up to 4096
    localparam int BEAT_BYTES = 4;
    localparam int BEAT_LSB   = $clog2(BEAT_BYTES);

    typedef enum logic [1:0] {
        STAT_OK     = 2'b00,
        STAT_BUSERR = 2'b01,
        STAT_CFGERR = 2'b10
    } stat_code_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_DONE     = 3'd5
    } xfer_state_t;

    // True when a byte address or count is not a whole number of beats.
    function automatic logic beat_misaligned(input logic [ADDR_W-1:0] v);
        return |v[BEAT_LSB-1:0];
    endfunction

endpackage

// File: rtl/dma_chunk_calc.sv
// Combinational burst sizing.
//   rem_i   : bytes still to transfer
//   src_i   : current source byte address
//   dst_i   : current destination byte address
//   bytes_o : size of the next burst = min(rem, room to the next MBB boundary
//             on the source side, room to the next MBB boundary on the
//             destination side). Because MBB divides 4096, no burst can
//             straddle a 4KB page on either side.
module dma_chunk_calc
    import dma_pkg::*;
#(
    parameter int MAX_BURST_BYTES = 256
) (
    input  logic [ADDR_W-1:0]  rem_i,
    input  logic [ADDR_W-1:0]  src_i,
    input  logic [ADDR_W-1:0]  dst_i,
    output logic [BYTES_W-1:0] bytes_o
);

    localparam int OFF_W = $clog2(MAX_BURST_BYTES);
    localparam logic [BYTES_W-1:0] MBB = BYTES_W'(MAX_BURST_BYTES);

    logic [BYTES_W-1:0] src_room;
    logic [BYTES_W-1:0] dst_room;
    logic [BYTES_W-1:0] lim;

    assign src_room = MBB - BYTES_W'(src_i[OFF_W-1:0]);
    assign dst_room = MBB - BYTES_W'(dst_i[OFF_W-1:0]);
    assign lim      = (src_room < dst_room) ? src_room : dst_room;
    assign bytes_o  = (rem_i < ADDR_W'(lim)) ? rem_i[BYTES_W-1:0] : lim;

endmodule

// File: rtl/dma_xfer_ctrl.sv
// Transfer sequencer between the controller register file and the data mover.
// Takes a job (SrcAddr, DstAddr, Length) on GO_Pulse, splits it into paired
// read/write burst commands, tracks outstanding write bursts, and reports
// Busy / IRQStatus / StatCode plus the IRQ line.
//
// Ports
//   ACLK, ARESETn          clock, asynchronous active-low reset
//   GO_Pulse               start (honoured only when idle)
//   IRQEnable              interrupt enable level
//   IRQClear_Pulse         clears IRQStatus
//   SrcAddr/DstAddr/Length job description, sampled at GO
//   Busy, IRQStatus, StatCode, IRQ   status back to the register file
//   RdCmd*/WrCmd*          burst commands to the data mover
//   WrDoneValid/WrDoneErr  write burst completion (+error)
//   RdErr                  read bus error pulse
//   DbgState               current FSM state, for observation only
//
// Handshake: a command transfers on a rising ACLK edge where Valid and Ready
// are both high. Once Valid is raised, Addr and Bytes stay constant and Valid
// stays high until that transfer; read and write commands of a pair complete
// independently of each other.
module dma_xfer_ctrl
    import dma_pkg::*;
#(
    parameter int MAX_BURST_BYTES = 256,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                GO_Pulse,
    input  logic                IRQEnable,
    input  logic                IRQClear_Pulse,
    input  logic [ADDR_W-1:0]   SrcAddr,
    input  logic [ADDR_W-1:0]   DstAddr,
    input  logic [ADDR_W-1:0]   Length,
    output logic                Busy,
    output logic                IRQStatus,
    output logic [1:0]          StatCode,
    output logic                IRQ,
    output logic                RdCmdValid,
    input  logic                RdCmdReady,
    output logic [ADDR_W-1:0]   RdCmdAddr,
    output logic [BYTES_W-1:0]  RdCmdBytes,
    output logic                WrCmdValid,
    input  logic                WrCmdReady,
    output logic [ADDR_W-1:0]   WrCmdAddr,
    output logic [BYTES_W-1:0]  WrCmdBytes,
    input  logic                WrDoneValid,
    input  logic                WrDoneErr,
    input  logic                RdErr,
    output xfer_state_t         DbgState
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    xfer_state_t        state_q;
    stat_code_t         stat_q;
    logic [ADDR_W-1:0]  src_q, dst_q, rem_q;
    logic               err_q, busy_q, irq_q;
    logic               rd_valid_q, wr_valid_q;
    logic [ADDR_W-1:0]  rd_addr_q, wr_addr_q;
    logic [BYTES_W-1:0] rd_bytes_q, wr_bytes_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [BYTES_W-1:0] chunk;
    logic               rd_acc, wr_acc, done_ev, bus_err, acks_clear, cfg_bad;
    logic               issue_now;

    dma_chunk_calc #(
        .MAX_BURST_BYTES (MAX_BURST_BYTES)
    ) u_chunk (
        .rem_i   (rem_q),
        .src_i   (src_q),
        .dst_i   (dst_q),
        .bytes_o (chunk)
    );

    always_comb begin
        rd_acc  = rd_valid_q & RdCmdReady;
        wr_acc  = wr_valid_q & WrCmdReady;
        // A completion with nothing outstanding is dropped so the count never wraps.
        done_ev = WrDoneValid & (cnt_q != '0);
        bus_err = (WrDoneValid & WrDoneErr) | RdErr;
        // Both halves of the current pair are gone after this edge.
        acks_clear = (~rd_valid_q | RdCmdReady) & (~wr_valid_q | WrCmdReady);
        cfg_bad = beat_misaligned(src_q) | beat_misaligned(dst_q) | beat_misaligned(rem_q);

        cnt_d = cnt_q;
        if (wr_acc && !done_ev) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!wr_acc && done_ev) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        // The first pair is loaded straight out of CHECK (the count is always
        // zero there) so the read command is up two cycles after GO; later
        // pairs are loaded from ISSUE once a write slot is free.
        issue_now = 1'b0;
        if (state_q == ST_CHECK) begin
            issue_now = !cfg_bad && (rem_q != '0);
        end else if (state_q == ST_ISSUE) begin
            issue_now = !err_q && !bus_err && (cnt_q < MAX_CNT);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= ST_IDLE;
            stat_q     <= STAT_OK;
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            irq_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            rd_bytes_q <= '0;
            wr_bytes_q <= '0;
            cnt_q      <= '0;
        end else begin
            cnt_q <= cnt_d;

            if (rd_acc) rd_valid_q <= 1'b0;
            if (wr_acc) wr_valid_q <= 1'b0;

            // Clear first so a DONE in the same cycle wins.
            if (IRQClear_Pulse) irq_q <= 1'b0;

            if (state_q != ST_IDLE && bus_err) begin
                err_q  <= 1'b1;
                stat_q <= STAT_BUSERR;
            end

            // Pointers advance as soon as a pair is loaded; the command
            // registers keep the burst's own address/size until accepted.
            if (issue_now) begin
                rd_valid_q <= 1'b1;
                wr_valid_q <= 1'b1;
                rd_addr_q  <= src_q;
                wr_addr_q  <= dst_q;
                rd_bytes_q <= chunk;
                wr_bytes_q <= chunk;
                src_q      <= src_q + ADDR_W'(chunk);
                dst_q      <= dst_q + ADDR_W'(chunk);
                rem_q      <= rem_q - ADDR_W'(chunk);
            end

            case (state_q)
                ST_IDLE: begin
                    if (GO_Pulse) begin
                        src_q   <= SrcAddr;
                        dst_q   <= DstAddr;
                        rem_q   <= Length;
                        stat_q  <= STAT_OK;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (cfg_bad) begin
                        stat_q  <= STAT_CFGERR;
                        state_q <= ST_DONE;
                    end else if (rem_q == '0) begin
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_WAIT_ACK;
                    end
                end
                ST_ISSUE: begin
                    if (err_q || bus_err) begin
                        state_q <= ST_DRAIN;
                    end else if (issue_now) begin
                        state_q <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (acks_clear) begin
                        if (err_q || bus_err || rem_q == '0) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == '0) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    irq_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Busy       = busy_q;
    assign IRQStatus  = irq_q;
    assign StatCode   = stat_q;
    assign IRQ        = irq_q & IRQEnable;
    assign RdCmdValid = rd_valid_q;
    assign RdCmdAddr  = rd_addr_q;
    assign RdCmdBytes = rd_bytes_q;
    assign WrCmdValid = wr_valid_q;
    assign WrCmdAddr  = wr_addr_q;
    assign WrCmdBytes = wr_bytes_q;
    assign DbgState   = state_q;

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
module tb_dma_xfer_ctrl;
    import dma_pkg::*;

    localparam int MBB  = 256;
    localparam int MAXO = 4;

    // ---------------- clock / reset / signals ----------------
    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        GO_Pulse = 1'b0;
    logic        IRQEnable = 1'b0;
    logic        IRQClear_Pulse = 1'b0;
    logic [31:0] SrcAddr = '0, DstAddr = '0, Length = '0;
    logic        Busy, IRQStatus, IRQ;
    logic [1:0]  StatCode;
    logic        RdCmdValid, WrCmdValid;
    logic        RdCmdReady = 1'b0, WrCmdReady = 1'b0;
    logic [31:0] RdCmdAddr, WrCmdAddr;
    logic [12:0] RdCmdBytes, WrCmdBytes;
    logic        WrDoneValid = 1'b0, WrDoneErr = 1'b0, RdErr = 1'b0;
    xfer_state_t DbgState;

    always #5 ACLK = ~ACLK;

    dma_xfer_ctrl #(
        .MAX_BURST_BYTES (MBB),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .ACLK           (ACLK),
        .ARESETn        (ARESETn),
        .GO_Pulse       (GO_Pulse),
        .IRQEnable      (IRQEnable),
        .IRQClear_Pulse (IRQClear_Pulse),
        .SrcAddr        (SrcAddr),
        .DstAddr        (DstAddr),
        .Length         (Length),
        .Busy           (Busy),
        .IRQStatus      (IRQStatus),
        .StatCode       (StatCode),
        .IRQ            (IRQ),
        .RdCmdValid     (RdCmdValid),
        .RdCmdReady     (RdCmdReady),
        .RdCmdAddr      (RdCmdAddr),
        .RdCmdBytes     (RdCmdBytes),
        .WrCmdValid     (WrCmdValid),
        .WrCmdReady     (WrCmdReady),
        .WrCmdAddr      (WrCmdAddr),
        .WrCmdBytes     (WrCmdBytes),
        .WrDoneValid    (WrDoneValid),
        .WrDoneErr      (WrDoneErr),
        .RdErr          (RdErr),
        .DbgState       (DbgState)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_fail = 0;
    logic [44:0] rd_exp_q[$];
    logic [44:0] wr_exp_q[$];
    logic [1:0]  done_exp_q[$];
    int done_cnt = 0;
    int exp_done_total = 0;
    int wr_acc_cnt = 0;
    int done_issued = 0;
    int rd_mode = 0;     // 0 always ready, 1 random, 2 never
    int wr_mode = 0;
    bit done_en = 1'b1;
    int err_req = 0, err_used = 0;
    int stray_req = 0, stray_used = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: walk the job with plain arithmetic and queue the
    // expected bursts and final status. limit>0 keeps only the first bursts.
    task automatic model_push(input logic [31:0] s, input logic [31:0] d,
                              input logic [31:0] l, input int limit,
                              input logic [1:0] st);
        int unsigned src, dst, rem, c, room;
        int n;
        src = s; dst = d; rem = l; n = 0;
        if (((s | d | l) & 32'h3) != 0) begin
            done_exp_q.push_back(STAT_CFGERR);
        end else begin
            while (rem != 0 && (limit == 0 || n < limit)) begin
                c = rem;
                room = MBB - (src % MBB);
                if (room < c) c = room;
                room = MBB - (dst % MBB);
                if (room < c) c = room;
                rd_exp_q.push_back({src, 13'(c)});
                wr_exp_q.push_back({dst, 13'(c)});
                src += c; dst += c; rem -= c; n++;
            end
            done_exp_q.push_back(st);
        end
        exp_done_total++;
    endtask

    // ---------------- drivers ----------------
    always @(posedge ACLK) begin
        #1;
        case (rd_mode)
            0:       RdCmdReady = 1'b1;
            1:       RdCmdReady = ($urandom_range(0, 2) != 0);
            default: RdCmdReady = 1'b0;
        endcase
        case (wr_mode)
            0:       WrCmdReady = 1'b1;
            1:       WrCmdReady = ($urandom_range(0, 2) != 0);
            default: WrCmdReady = 1'b0;
        endcase
    end

    // Write-completion responder: one done per accepted write burst.
    always @(posedge ACLK) begin
        #1;
        WrDoneValid = 1'b0;
        WrDoneErr = 1'b0;
        if (!ARESETn) begin
            done_issued = wr_acc_cnt;
        end else if (stray_req > stray_used) begin
            WrDoneValid = 1'b1;
            stray_used++;
        end else if (done_en && wr_acc_cnt > done_issued && $urandom_range(0, 2) == 0) begin
            WrDoneValid = 1'b1;
            done_issued++;
            if (err_req > err_used) begin
                WrDoneErr = 1'b1;
                err_used++;
            end
        end
    end

    task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        @(posedge ACLK); #1;
        GO_Pulse = 1'b1; SrcAddr = s; DstAddr = d; Length = l;
        @(posedge ACLK); #1;
        GO_Pulse = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 5000 && done_cnt < exp_done_total; i++) @(posedge ACLK);
        #1;
        n_cmp++;
        if (done_cnt < exp_done_total) begin
            n_fail++;
            $display("FAIL done_timeout: got %0d completions expected %0d", done_cnt, exp_done_total);
        end
    endtask

    task automatic wait_wr(input int target);
        for (int i = 0; i < 2000 && wr_acc_cnt < target; i++) @(posedge ACLK);
        #1;
        n_cmp++;
        if (wr_acc_cnt < target) begin
            n_fail++;
            $display("FAIL wr_accept_timeout: got %0d expected %0d", wr_acc_cnt, target);
        end
    endtask

    // ---------------- monitor ----------------
    logic        busy_prev = 1'b0;
    logic        rd_hold = 1'b0, wr_hold = 1'b0;
    logic [44:0] rd_hold_v, wr_hold_v;

    always @(negedge ACLK) begin
        logic [44:0] e;
        logic [1:0]  es;
        if (!ARESETn) begin
            busy_prev = 1'b0;
            rd_hold = 1'b0;
            wr_hold = 1'b0;
        end else begin
            if (rd_hold) check("rd_stable", {RdCmdValid, RdCmdAddr, RdCmdBytes}, {1'b1, rd_hold_v});
            if (wr_hold) check("wr_stable", {WrCmdValid, WrCmdAddr, WrCmdBytes}, {1'b1, wr_hold_v});
            if (RdCmdValid && RdCmdReady) begin
                if (rd_exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL rd_cmd_unexpected: got addr 0x%0h bytes 0x%0h expected none", RdCmdAddr, RdCmdBytes);
                end else begin
                    e = rd_exp_q.pop_front();
                    check("rd_cmd", {RdCmdAddr, RdCmdBytes}, e);
                end
            end
            if (WrCmdValid && WrCmdReady) begin
                wr_acc_cnt++;
                if (wr_exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL wr_cmd_unexpected: got addr 0x%0h bytes 0x%0h expected none", WrCmdAddr, WrCmdBytes);
                end else begin
                    e = wr_exp_q.pop_front();
                    check("wr_cmd", {WrCmdAddr, WrCmdBytes}, e);
                end
            end
            rd_hold = RdCmdValid && !RdCmdReady;
            rd_hold_v = {RdCmdAddr, RdCmdBytes};
            wr_hold = WrCmdValid && !WrCmdReady;
            wr_hold_v = {WrCmdAddr, WrCmdBytes};
            if (busy_prev && !Busy) begin
                done_cnt++;
                if (done_exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL done_unexpected: got stat %0d expected no completion", StatCode);
                end else begin
                    es = done_exp_q.pop_front();
                    check("done_stat_irq", {StatCode, IRQStatus}, {es, 1'b1});
                    check("done_no_missing_cmds", 64'(rd_exp_q.size() + wr_exp_q.size()), 64'd0);
                end
            end
            busy_prev = Busy;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int base;
        logic [31:0] s, d, l;

        repeat (3) @(posedge ACLK);
        #1;
        check("reset_outputs",
              {Busy, IRQStatus, StatCode, IRQ, RdCmdValid, WrCmdValid, RdCmdAddr, RdCmdBytes},
              '0);
        check("reset_wr_outputs", {WrCmdAddr, WrCmdBytes}, '0);
        check("reset_state", 64'(DbgState), 64'(ST_IDLE));
        @(posedge ACLK); #1;
        ARESETn = 1'b1;

        // Single aligned burst, with GO-to-command latency.
        rd_mode = 0; wr_mode = 0; done_en = 1'b1; IRQEnable = 1'b0;
        model_push(32'h1000, 32'h2000, 32'h100, 0, STAT_OK);
        go(32'h1000, 32'h2000, 32'h100);
        check("busy_after_go", {Busy, RdCmdValid}, 2'b10);
        @(posedge ACLK); #1;
        check("rd_valid_2_after_go", {RdCmdValid, WrCmdValid}, 2'b11);
        wait_done();
        check("idle_after_done", {Busy, StatCode, IRQStatus}, {1'b0, 2'b00, 1'b1});
        check("irq_masked", IRQ, 1'b0);
        IRQEnable = 1'b1;
        #1;
        check("irq_enabled", IRQ, 1'b1);
        @(posedge ACLK); #1; IRQClear_Pulse = 1'b1;
        @(posedge ACLK); #1; IRQClear_Pulse = 1'b0;
        check("irq_cleared", {IRQStatus, IRQ}, 2'b00);

        // Boundary split, read stalled 5 cycles, GO while busy ignored.
        rd_mode = 2;
        model_push(32'h10F0, 32'h2000, 32'h40, 0, STAT_OK);
        go(32'h10F0, 32'h2000, 32'h40);
        repeat (3) @(posedge ACLK);
        #1;
        GO_Pulse = 1'b1; SrcAddr = 32'h7777_0000; DstAddr = 32'h8888_0000; Length = 32'h800;
        @(posedge ACLK); #1;
        GO_Pulse = 1'b0;
        @(posedge ACLK); #1;
        rd_mode = 1;
        wait_done();

        // Zero length and misaligned source.
        model_push(32'h1000, 32'h2000, 32'h0, 0, STAT_OK);
        go(32'h1000, 32'h2000, 32'h0);
        wait_done();
        model_push(32'h1002, 32'h2000, 32'h40, 0, STAT_OK);
        go(32'h1002, 32'h2000, 32'h40);
        wait_done();

        // IRQ set and clear in the same cycle leaves it set.
        @(posedge ACLK); #1; IRQClear_Pulse = 1'b1;
        @(posedge ACLK); #1; IRQClear_Pulse = 1'b0;
        check("irq_clear_before_set", IRQStatus, 1'b0);
        model_push(32'h0, 32'h0, 32'h0, 0, STAT_OK);
        go(32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 20 && DbgState != ST_DONE; i++) begin
            @(posedge ACLK); #1;
        end
        IRQClear_Pulse = 1'b1;
        @(posedge ACLK); #1;
        IRQClear_Pulse = 1'b0;
        check("irq_set_beats_clear", IRQStatus, 1'b1);
        wait_done();

        // Stray completion while idle must not disturb the outstanding count.
        stray_req++;
        repeat (3) @(posedge ACLK);

        // Stall at MAX_OUTSTANDING, then a write error stops issuing.
        rd_mode = 1; wr_mode = 1; done_en = 1'b0;
        base = wr_acc_cnt;
        model_push(32'h4000, 32'h8000, 32'h1000, MAXO, STAT_BUSERR);
        go(32'h4000, 32'h8000, 32'h1000);
        wait_wr(base + MAXO);
        repeat (20) @(posedge ACLK);
        #1;
        check("stall_at_max", {Busy, 32'(wr_acc_cnt - base)}, {1'b1, 32'(MAXO)});
        err_req++;
        done_en = 1'b1;
        wait_done();

        // Same stall, then a read error.
        done_en = 1'b0;
        base = wr_acc_cnt;
        model_push(32'h4000, 32'h8000, 32'h1000, MAXO, STAT_BUSERR);
        go(32'h4000, 32'h8000, 32'h1000);
        wait_wr(base + MAXO);
        repeat (5) @(posedge ACLK);
        #1; RdErr = 1'b1;
        @(posedge ACLK); #1; RdErr = 1'b0;
        done_en = 1'b1;
        wait_done();

        // Randomized jobs.
        for (int t = 0; t < 14; t++) begin
            s = 32'($urandom_range(0, 32'hFFFF)) & 32'hFFFF_FFFC;
            d = 32'($urandom_range(0, 32'hFFFF)) & 32'hFFFF_FFFC;
            l = 32'($urandom_range(0, 32'h180)) * 32'd4;
            if ($urandom_range(0, 7) == 0) l = l | 32'h2;
            if ($urandom_range(0, 9) == 0) d = d | 32'h1;
            rd_mode = $urandom_range(0, 1);
            wr_mode = $urandom_range(0, 1);
            model_push(s, d, l, 0, STAT_OK);
            go(s, d, l);
            wait_done();
        end

        // Reset in the middle of a burst.
        rd_mode = 2; wr_mode = 2;
        model_push(32'h1000, 32'h2000, 32'h200, 0, STAT_OK);
        go(32'h1000, 32'h2000, 32'h200);
        for (int i = 0; i < 20 && !RdCmdValid; i++) begin
            @(posedge ACLK); #1;
        end
        check("valid_before_reset", RdCmdValid, 1'b1);
        ARESETn = 1'b0;
        #1;
        check("midreset_outputs",
              {Busy, IRQStatus, StatCode, IRQ, RdCmdValid, WrCmdValid, RdCmdAddr, RdCmdBytes},
              '0);
        check("midreset_wr_outputs", {WrCmdAddr, WrCmdBytes}, '0);
        rd_exp_q.delete();
        wr_exp_q.delete();
        done_exp_q.delete();
        exp_done_total = done_cnt;
        repeat (3) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        rd_mode = 1; wr_mode = 1;
        model_push(32'h3000, 32'h50C0, 32'h180, 0, STAT_OK);
        go(32'h3000, 32'h50C0, 32'h180);
        wait_done();

        repeat (5) @(posedge ACLK);
        check("queues_empty", 64'(rd_exp_q.size() + wr_exp_q.size() + done_exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
